// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target and master FSM encodings, bus constants
// and small helpers used by the I2C blocks.
`timescale 1ns/1ps
package i2c_pkg;

    // Target FSM encodings (visible on the target's state port)
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } slave_state_t;

    // Master FSM encodings, kept here so both sides share one definition
    typedef enum logic [3:0] {
        MS_IDLE      = 4'd0,
        MS_START     = 4'd1,
        MS_ADDR      = 4'd2,
        MS_ADDR_ACK  = 4'd3,
        MS_WDATA     = 4'd4,
        MS_WDATA_ACK = 4'd5,
        MS_RDATA     = 4'd6,
        MS_RDATA_ACK = 4'd7,
        MS_STOP      = 4'd8
    } master_state_t;

    // Level of SDA during the 9th clock
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // R/W bit value in the address byte that selects a read
    localparam logic RW_READ = 1'b1;

    // Append one sampled bit to the seven already collected, MSB first
    function automatic logic [7:0] next_byte(input logic [6:0] shift, input logic bit_in);
        return {shift, bit_in};
    endfunction

endpackage

// File: rtl/i2c_reg_file.sv
// Register storage for the I2C target: NREG x 8 bits, one write port,
// one combinational read port, cleared on reset.
`timescale 1ns/1ps
module i2c_reg_file
    import i2c_pkg::*;
#(
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_reg [NREG];

    // Write port; every location clears on reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREG; i++) mem_reg[i] <= '0;
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/i2c_slave_target.sv
// I2C register target: answers at DEV_ADDR, first written byte sets the
// register pointer, further written bytes store at the auto-incrementing
// pointer, reads stream registers out from the pointer.
`timescale 1ns/1ps
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NREG     = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [3:0] state
);

    localparam int AW = $clog2(NREG);

    logic scl_meta_reg, scl_sync_reg, scl_hist_reg;
    logic sda_meta_reg, sda_sync_reg, sda_hist_reg;

    slave_state_t  state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [6:0]    shift_reg;
    logic [AW-1:0] ptr_reg;
    logic          rw_reg;
    logic          ack_drv_reg;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       byte_state, byte_done, wr_en;
    logic [7:0] byte_in, rd_data;

    // Two-flop synchronizers plus one history flop per bus line; idle bus is high
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            scl_meta_reg <= 1'b1;
            scl_sync_reg <= 1'b1;
            scl_hist_reg <= 1'b1;
            sda_meta_reg <= 1'b1;
            sda_sync_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_meta_reg <= scl_in;
            scl_sync_reg <= scl_meta_reg;
            scl_hist_reg <= scl_sync_reg;
            sda_meta_reg <= sda_in;
            sda_sync_reg <= sda_meta_reg;
            sda_hist_reg <= sda_sync_reg;
        end
    end

    assign scl_rise  = scl_sync_reg & ~scl_hist_reg;
    assign scl_fall  = ~scl_sync_reg & scl_hist_reg;
    assign start_det = scl_sync_reg & sda_hist_reg & ~sda_sync_reg;
    assign stop_det  = scl_sync_reg & ~sda_hist_reg & sda_sync_reg;

    assign byte_state = (state_reg == ST_ADDR) || (state_reg == ST_PTR) ||
                        (state_reg == ST_WDATA) || (state_reg == ST_RDATA);
    assign byte_in    = next_byte(shift_reg, sda_sync_reg);
    assign byte_done  = scl_rise && (bit_cnt_reg == 3'd7);
    // A bus condition in the same cycle wins, so a cut-short byte never stores
    assign wr_en      = (state_reg == ST_WDATA) && byte_done && !start_det && !stop_det;

    i2c_reg_file #(.NREG(NREG), .AW(AW)) u_regs (
        .clk   (clk),
        .nrst  (nrst),
        .we    (wr_en),
        .waddr (ptr_reg),
        .wdata (byte_in),
        .raddr (ptr_reg),
        .rdata (rd_data)
    );

    // Protocol FSM: START/STOP override everything, otherwise step on synced SCL edges
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ptr_reg     <= '0;
            rw_reg      <= 1'b0;
            ack_drv_reg <= 1'b0;
            sda_oe      <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state_reg   <= ST_ADDR;
                bit_cnt_reg <= '0;
                ack_drv_reg <= 1'b0;
                sda_oe      <= 1'b0;
            end else if (stop_det) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= '0;
                ack_drv_reg <= 1'b0;
                sda_oe      <= 1'b0;
            end else begin
                // The 3-bit counter wraps back to 0 on the 8th rise
                if (scl_rise && byte_state) begin
                    shift_reg   <= byte_in[6:0];
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                case (state_reg)
                    ST_ADDR: begin
                        if (byte_done) begin
                            rw_reg    <= byte_in[0];
                            state_reg <= (byte_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        // First fall starts the ACK pulse, second fall ends it
                        if (scl_fall) begin
                            if (!ack_drv_reg) begin
                                sda_oe      <= 1'b1;
                                ack_drv_reg <= 1'b1;
                            end else begin
                                ack_drv_reg <= 1'b0;
                                bit_cnt_reg <= '0;
                                sda_oe      <= 1'b0;
                                if (state_reg != ST_ADDR_ACK) begin
                                    state_reg <= ST_WDATA;
                                end else if (rw_reg == RW_READ) begin
                                    state_reg <= ST_RDATA;
                                    sda_oe    <= ~rd_data[7];
                                end else begin
                                    state_reg <= ST_PTR;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (byte_done) begin
                            ptr_reg   <= byte_in[AW-1:0];
                            state_reg <= ST_PTR_ACK;
                        end
                    end
                    ST_WDATA: begin
                        if (byte_done) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= 8'(ptr_reg);
                            wr_data   <= byte_in;
                            ptr_reg   <= ptr_reg + 1'b1;
                            state_reg <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: begin
                        // After k rises the counter holds k, so bit 7-k goes out next
                        if (byte_done) begin
                            state_reg <= ST_RDATA_ACK;
                        end else if (scl_fall) begin
                            sda_oe <= ~rd_data[3'd7 - bit_cnt_reg];
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                        end else if (scl_rise) begin
                            if (sda_sync_reg == NACK) begin
                                state_reg <= ST_WAIT_STOP;
                            end else begin
                                ptr_reg     <= ptr_reg + 1'b1;
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_RDATA;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = state_reg;
    assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-banged I2C master, transaction-level
// register/pointer model, per-cycle output compare, directed and random traffic.
`timescale 1ns/1ps
module tb_i2c_slave_target;
    import i2c_pkg::*;

    localparam logic [6:0] DEV  = 7'h50;
    localparam int         NREG = 4;
    localparam int         Q    = 5;
    localparam int         H    = 10;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data;
    logic [3:0] state;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_target #(.DEV_ADDR(DEV), .NREG(NREG)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .scl_in    (scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Transaction-level model of the target
    logic [7:0] model_regs [NREG];
    int         model_ptr = 0;
    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_wr [$];
    wr_t        e;

    logic [7:0] wbuf [8];
    logic [7:0] rd_buf [4];
    int         strobe_cnt = 0;
    logic [7:0] last_a = '0, last_d = '0;
    logic       may_drive = 1'b0;
    logic       compare_en = 1'b0;
    logic       log_en = 1'b0;
    logic [3:0] prev_st = '0;
    logic [3:0] st_log [$];

    function automatic void check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endfunction

    // Per-cycle compare: busy/state consistency, no drive outside allowed windows, strobes vs model
    always @(negedge clk) begin
        if (compare_en) begin
            check("busy_vs_state", int'(busy), int'(state != 4'd0));
            if (!may_drive) check("sda_oe_released", int'(sda_oe), 0);
            if (wr_strobe) begin
                strobe_cnt++;
                last_a = wr_addr;
                last_d = wr_data;
                if (exp_wr.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", int'(wr_addr), int'(e.a));
                    check("wr_data", int'(wr_data), int'(e.d));
                end
            end
            if (log_en && state != prev_st) st_log.push_back(state);
            prev_st = state;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // nxt: whether the target may pull SDA during the next bit slot
    task automatic send_bit(input logic b, input logic nxt);
        m_sda = b;
        tick(Q);
        scl = 1'b1;
        tick(H);
        scl = 1'b0;
        may_drive = may_drive | nxt;
        tick(Q);
        may_drive = nxt;
    endtask

    task automatic recv_bit(output logic b, input logic nxt);
        m_sda = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(H / 2);
        b = sda_bus;
        tick(H / 2);
        scl = 1'b0;
        may_drive = may_drive | nxt;
        tick(Q);
        may_drive = nxt;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input logic drive_after,
                             output logic ack);
        for (int i = 7; i > 0; i--) send_bit(d[i], 1'b0);
        send_bit(d[0], exp_ack);
        recv_bit(ack, drive_after);
    endtask

    task automatic do_start();
        m_sda = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic do_stop();
        m_sda = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
        tick(10);
    endtask

    // Address byte, then wbuf[0..nbytes-1], then abort_bits bits of wbuf[nbytes]
    task automatic write_txn(input logic [6:0] a7, input logic rw, input int nbytes,
                             input int abort_bits, input logic stop_at_end);
        logic ack;
        logic match;
        match = (a7 == DEV) && !rw;
        do_start();
        send_byte({a7, rw}, match, 1'b0, ack);
        check("addr_ack", int'(ack), match ? 0 : 1);
        for (int i = 0; i < nbytes; i++) begin
            if (match) begin
                if (i == 0) begin
                    model_ptr = int'(wbuf[0]) % NREG;
                end else begin
                    model_regs[model_ptr] = wbuf[i];
                    exp_wr.push_back({8'(model_ptr), wbuf[i]});
                    model_ptr = (model_ptr + 1) % NREG;
                end
            end
            send_byte(wbuf[i], match, 1'b0, ack);
            check("data_ack", int'(ack), match ? 0 : 1);
        end
        for (int i = 0; i < abort_bits; i++) send_bit(wbuf[nbytes][7-i], 1'b0);
        if (stop_at_end) do_stop();
        $display("txn write addr=0x%02h rw=%0d bytes=%0d abort_bits=%0d ptr_now=%0d",
                 a7, rw, nbytes, abort_bits, model_ptr);
    endtask

    // Read n bytes, ACK all but the last, NACK the last, then STOP
    task automatic read_txn(input int n);
        logic       ack, bt, last;
        logic [7:0] d;
        do_start();
        send_byte({DEV, 1'b1}, 1'b1, 1'b1, ack);
        check("raddr_ack", int'(ack), 0);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            d = '0;
            for (int b = 7; b > 0; b--) begin
                recv_bit(bt, 1'b1);
                d[b] = bt;
            end
            recv_bit(bt, 1'b0);
            d[0] = bt;
            check("read_data", int'(d), int'(model_regs[model_ptr]));
            rd_buf[i] = d;
            send_bit(last, !last);
            if (!last) model_ptr = (model_ptr + 1) % NREG;
        end
        do_stop();
        $display("txn read bytes=%0d first=0x%02h ptr_now=%0d", n, rd_buf[0], model_ptr);
    endtask

    initial begin
        int sc0;
        int kind, n;
        logic [6:0] a;
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;

        // Reset values
        tick(3);
        check("rst_state", int'(state), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_wr_strobe", int'(wr_strobe), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        nrst = 1'b1;
        compare_en = 1'b1;
        tick(10);

        // Write 0xA5 to register 2
        sc0 = strobe_cnt;
        wbuf[0] = 8'h02; wbuf[1] = 8'hA5;
        write_txn(DEV, 1'b0, 2, 0, 1'b1);
        check("w1_strobes", strobe_cnt - sc0, 1);
        check("w1_last_addr", int'(last_a), 2);
        check("w1_last_data", int'(last_d), 8'hA5);
        check("w1_wr_addr_hold", int'(wr_addr), 2);
        check("w1_idle", int'(state), 0);

        // Set pointer 2, repeated START, read one byte
        wbuf[0] = 8'h02;
        write_txn(DEV, 1'b0, 1, 0, 1'b0);
        read_txn(1);
        check("r1_byte", int'(rd_buf[0]), 8'hA5);
        check("r1_idle", int'(state), 0);

        // Wrong address 0x52: no drive, no strobe, state 1 -> 9 -> 0
        sc0 = strobe_cnt;
        st_log.delete();
        log_en = 1'b1;
        wbuf[0] = 8'h11;
        write_txn(7'h52, 1'b0, 1, 0, 1'b1);
        log_en = 1'b0;
        check("na_strobes", strobe_cnt - sc0, 0);
        check("na_log_len", st_log.size(), 3);
        if (st_log.size() == 3) begin
            check("na_log0", int'(st_log[0]), 1);
            check("na_log1", int'(st_log[1]), 9);
            check("na_log2", int'(st_log[2]), 0);
        end

        // Pointer wrap: 0x11 to reg3, 0x22 to reg0
        sc0 = strobe_cnt;
        wbuf[0] = 8'h03; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        write_txn(DEV, 1'b0, 3, 0, 1'b1);
        check("wrap_strobes", strobe_cnt - sc0, 2);
        check("wrap_model_reg3", int'(model_regs[3]), 8'h11);
        wbuf[0] = 8'h03;
        write_txn(DEV, 1'b0, 1, 0, 1'b0);
        read_txn(2);
        check("wrap_reg3", int'(rd_buf[0]), 8'h11);
        check("wrap_reg0", int'(rd_buf[1]), 8'h22);

        // STOP after 4 bits of a data byte
        sc0 = strobe_cnt;
        wbuf[0] = 8'h01; wbuf[1] = 8'hF0;
        write_txn(DEV, 1'b0, 1, 4, 1'b1);
        check("abort_strobes", strobe_cnt - sc0, 0);
        check("abort_idle", int'(state), 0);

        // Reset pulsed during the address ACK
        do_start();
        for (int i = 7; i > 0; i--) send_bit(DEV[i-1], 1'b0);
        send_bit(1'b0, 1'b1);
        check("ack_before_rst", int'(sda_oe), 1);
        #2;
        nrst = 1'b0;
        m_sda = 1'b1;
        #1;
        check("rst_ack_sda_oe", int'(sda_oe), 0);
        check("rst_ack_state", int'(state), 0);
        check("rst_ack_busy", int'(busy), 0);
        check("rst_ack_wr_strobe", int'(wr_strobe), 0);
        check("rst_ack_wr_addr", int'(wr_addr), 0);
        check("rst_ack_wr_data", int'(wr_data), 0);
        $display("txn reset pulsed during address ACK");
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        model_ptr = 0;
        exp_wr.delete();
        may_drive = 1'b0;
        tick(3);
        nrst = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(10);
        check("post_rst_idle", int'(state), 0);
        read_txn(1);

        // Randomized traffic against the model
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(1, 4);
                    write_txn(DEV, 1'b0, n, 0, 1'b1);
                end
                1: begin
                    if ($urandom_range(0, 1) == 1) write_txn(DEV, 1'b0, 1, 0, 1'b0);
                    read_txn($urandom_range(1, 3));
                end
                2: begin
                    a = DEV ^ (7'd1 << $urandom_range(0, 6));
                    write_txn(a, 1'($urandom_range(0, 1)), 1, 0, 1'b1);
                end
                default: begin
                    n = $urandom_range(1, 2);
                    write_txn(DEV, 1'b0, n, $urandom_range(1, 7), 1'b1);
                end
            endcase
            check("rand_idle", int'(state), 0);
        end

        check("all_strobes_seen", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
